shader_instr_fetch: RTL and testbench
=====================================

// Module: shader_instr_fetch
// PURPOSE
//  Upstream of the SIMD execute stage: fetches 32-bit shader words from program memory,
//  buffers them in a small FIFO and presents decoded fields (op/mask/dest/srcA/srcB)
//  to the execute stage over a valid/ready handshake.
//  Replaces the fixed 16-entry ROM sequencer with a start/length-driven prefetcher.
// PARAMETERS
//  DEPTH    4   instruction FIFO entries (power of 2, >=2)
//  AW       8   program memory word-address width
// PORTS
//  clk         in   1   clock, rising edge
//  rst_n       in   1   asynchronous active-low reset
//  start       in   1   1-cycle pulse: begin program at base_addr (ignored unless IDLE)
//  base_addr   in   AW  first word address, sampled on start
//  prog_len    in   AW  number of words to fetch, sampled on start; 0 = none
//  flush       in   1   abort: empty FIFO, drop in-flight word, go IDLE
//  busy        out  1   high in FETCH or DRAIN
//  mem_req     out  1   read request, held until accepted
//  mem_addr    out  AW  word address, stable while mem_req=1
//  mem_gnt     in   1   request accepted this cycle (mem_req & mem_gnt)
//  mem_rvalid  in   1   read data valid, >=1 cycle after grant, in order
//  mem_rdata   in   32  read data
//  iv          out  1   decoded instruction valid (FIFO not empty)
//  ir          in   1   execute stage ready; transfer when iv & ir
//  op          out  2   head word [31:30]
//  mask        out  4   head word [29:26]
//  dest        out  3   head word [25:23]
//  src_a       out  3   head word [22:20]
//  src_b       out  3   head word [19:17]
// BEHAVIOUR
//  Reset: all outputs 0; FSM IDLE; FIFO empty; counters 0; discard flag 0.
//  FSM: IDLE -start&len!=0-> FETCH; IDLE -start&len==0-> stays IDLE.
//   FETCH -last word granted-> DRAIN; DRAIN -no word in flight & FIFO empty-> IDLE.
//   flush from any state -> IDLE next cycle (flush beats start in the same cycle).
//  Max one outstanding read. Request only when count + inflight < DEPTH (credit rule),
//   so a response always has a free slot; no backpressure on mem_rvalid.
//  mem_addr = base_addr + words_granted, wraps modulo 2^AW.
//  Grant of last word (granted == prog_len-1): mem_req drops the next cycle.
//  Response pushes mem_rdata into FIFO; push and pop in one cycle keep count unchanged.
//  Decoded outputs combinational from FIFO head; 0 when FIFO empty. Bits [16:0] ignored.
//  Latency: grant-to-rvalid N cycles -> iv rises the cycle after rvalid.
//  flush: FIFO pointers/count cleared, mem_req deasserted next cycle; if a word is in
//   flight, discard flag set and that response dropped; new start is blocked (busy stays 1)
//   until the dropped response returns.
//  iv never depends on ir; data stable while iv & !ir.
//  start while busy: ignored. Async reset mid-program: immediate return to reset state.
// STRUCTURE
//  Package shader_pkg: instruction field positions (OP_HI..SRCB_LO), op codes
//   OP_ADD=0, OP_MUL=1, OP_AND=2, OP_OR=3, FSM state encodings.
//  One sub-module: shader_instr_fifo (DEPTH x 32, push/pop, count, full/empty).
//  FSM, credit counter and address generator live in top.
// TESTING
//  1 start base=0x10 len=3, gnt=1, rvalid 1 cycle later, ir=1 -> addrs 10,11,12; 3
//    instructions out in order; busy low 1 cycle after last pop.
//  2 word 0x7C140000 -> op=1 mask=F dest=0 src_a=1 src_b=2.
//  3 ir=0, len=8 -> exactly 4 words fetched, mem_req low while full; ir=1 resumes to 8.
//  4 flush 1 cycle after grant, rvalid 3 cycles later -> word dropped, iv stays 0,
//    start blocked until rvalid, then accepted.
//  5 base=0xFE len=4 -> addrs FE,FF,00,01; start with len=0 -> busy stays 0.
//  6 rst_n low mid-FETCH with 2 queued -> iv, mem_req, busy 0 asynchronously.

Source files
------------

// File: rtl/shader_pkg.sv
// Shared definitions for the shader instruction fetch unit:
// instruction field positions, op codes and fetch FSM states.
package shader_pkg;

  localparam int OP_HI   = 31;
  localparam int OP_LO   = 30;
  localparam int MASK_HI = 29;
  localparam int MASK_LO = 26;
  localparam int DEST_HI = 25;
  localparam int DEST_LO = 23;
  localparam int SRCA_HI = 22;
  localparam int SRCA_LO = 20;
  localparam int SRCB_HI = 19;
  localparam int SRCB_LO = 17;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_MUL = 2'd1,
    OP_AND = 2'd2,
    OP_OR  = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/shader_instr_fifo.sv
// DEPTH x 32 instruction FIFO with synchronous clear.
// Ports: clear/push/pop in, head word, count, full/empty out.
module shader_instr_fifo #(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear_i,
  input  logic          push_i,
  input  logic [31:0]   data_i,
  input  logic          pop_i,
  output logic [31:0]   head_o,
  output logic [CW-1:0] count_o,
  output logic          full_o,
  output logic          empty_o
);

  logic [31:0]   mem_q [DEPTH];
  logic [PW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] cnt_q;
  logic          do_push, do_pop;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign head_o  = mem_q[rptr_q];
  assign count_o = cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else if (clear_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + PW'(1);
      if (do_pop)  rptr_q <= rptr_q + PW'(1);
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clear_i) mem_q[wptr_q] <= data_i;
  end

endmodule

// File: rtl/shader_instr_fetch.sv
// Start/length-driven shader word prefetcher feeding the SIMD
// execute stage. Ports: start/base/len/flush control, one-
// outstanding memory read port, decoded iv/ir instruction port.
module shader_instr_fetch #(
  parameter int DEPTH = 4,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic [AW-1:0] prog_len,
  input  logic          flush,
  output logic          busy,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  input  logic          mem_gnt,
  input  logic          mem_rvalid,
  input  logic [31:0]   mem_rdata,
  output logic          iv,
  input  logic          ir,
  output logic [1:0]    op,
  output logic [3:0]    mask,
  output logic [2:0]    dest,
  output logic [2:0]    src_a,
  output logic [2:0]    src_b
);
  import shader_pkg::*;

  localparam int CW = $clog2(DEPTH) + 1;

  state_e        state_q, state_d;
  logic [AW-1:0] base_q, base_d;
  logic [AW-1:0] len_q, len_d;
  logic [AW-1:0] gcnt_q, gcnt_d;
  logic          infl_q, infl_d;
  logic          disc_q, disc_d;

  logic [CW-1:0] cnt;
  logic          full, empty;
  logic [31:0]   head;
  logic          grant, push, pop;
  logic          last_gnt, start_ok, drain_done;
  logic          unused_lo;

  assign grant    = mem_req && mem_gnt;
  assign pop      = iv && ir;
  assign push     = mem_rvalid && infl_q && !disc_q && !flush;
  assign last_gnt = grant && (gcnt_q == len_q - AW'(1));
  assign start_ok = start && !flush && !disc_q
                 && (prog_len != '0);
  // Empty after this cycle's pop, nothing left to arrive.
  assign drain_done = !infl_q
                   && (empty || (cnt == CW'(1) && pop));

  // One read in flight at most, so the credit check
  // count + inflight < DEPTH reduces to !inflight && !full.
  assign mem_req  = (state_q == S_FETCH) && !infl_q && !full;
  assign mem_addr = base_q + gcnt_q;
  assign busy     = (state_q != S_IDLE) || disc_q;

  assign iv    = !empty;
  assign op    = iv ? head[OP_HI:OP_LO]     : '0;
  assign mask  = iv ? head[MASK_HI:MASK_LO] : '0;
  assign dest  = iv ? head[DEST_HI:DEST_LO] : '0;
  assign src_a = iv ? head[SRCA_HI:SRCA_LO] : '0;
  assign src_b = iv ? head[SRCB_HI:SRCB_LO] : '0;
  assign unused_lo = ^head[SRCB_LO-1:0];

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    len_d   = len_q;
    gcnt_d  = gcnt_q;
    infl_d  = infl_q;
    disc_d  = disc_q;
    if (mem_rvalid && infl_q) begin
      infl_d = 1'b0;
      disc_d = 1'b0;
    end
    if (grant) begin
      infl_d = 1'b1;
      gcnt_d = gcnt_q + AW'(1);
    end
    unique case (state_q)
      S_IDLE: begin
        if (start_ok) begin
          state_d = S_FETCH;
          base_d  = base_addr;
          len_d   = prog_len;
          gcnt_d  = '0;
        end
      end
      S_FETCH: if (last_gnt)   state_d = S_DRAIN;
      S_DRAIN: if (drain_done) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // A read still owed by memory must be swallowed.
    if (flush) begin
      state_d = S_IDLE;
      infl_d  = (infl_q && !mem_rvalid) || grant;
      disc_d  = infl_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      base_q  <= '0;
      len_q   <= '0;
      gcnt_q  <= '0;
      infl_q  <= 1'b0;
      disc_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      len_q   <= len_d;
      gcnt_q  <= gcnt_d;
      infl_q  <= infl_d;
      disc_q  <= disc_d;
    end
  end

  shader_instr_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear_i (flush),
    .push_i  (push),
    .data_i  (mem_rdata),
    .pop_i   (pop),
    .head_o  (head),
    .count_o (cnt),
    .full_o  (full),
    .empty_o (empty)
  );

endmodule

// File: tb/tb_shader_instr_fetch.sv
// Randomized bench for shader_instr_fetch with a queue-based
// reference model and a per-cycle compare process.
module tb_shader_instr_fetch;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [7:0]  base_addr = '0;
  logic [7:0]  prog_len = '0;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        ir = 1'b0;
  logic        busy, mem_req, iv;
  logic [7:0]  mem_addr;
  logic [1:0]  op;
  logic [3:0]  mask;
  logic [2:0]  dest, src_a, src_b;

  always #5 clk = ~clk;

  shader_instr_fetch #(.DEPTH(DEPTH), .AW(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .base_addr(base_addr), .prog_len(prog_len),
    .flush(flush), .busy(busy), .mem_req(mem_req),
    .mem_addr(mem_addr), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .iv(iv), .ir(ir), .op(op), .mask(mask),
    .dest(dest), .src_a(src_a), .src_b(src_b)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // ---------------- memory environment ----------------
  logic [31:0] pmem [256];
  int gnt_pct = 100, ir_pct = 100;
  int lat_min = 1, lat_max = 1;
  int hs_cnt = 0;
  logic [7:0] hs_addr [$];
  bit pend_v = 0, last_hs = 0, last_rv = 0;
  int pend_cnt = 0;
  logic [31:0] pend_data = '0;
  logic [7:0] last_addr = '0;

  initial forever begin
    @(negedge clk); #1;
    if (!rst_n) begin
      pend_v = 0; last_hs = 0; last_rv = 0;
      mem_rvalid = 1'b0; mem_gnt = 1'b0;
    end else begin
      if (last_rv) pend_v = 0;
      if (last_hs) begin
        pend_v = 1;
        pend_cnt = int'($urandom_range(lat_max, lat_min));
        pend_data = pmem[last_addr];
      end
      if (pend_v && pend_cnt == 1) begin
        mem_rvalid = 1'b1;
        mem_rdata = pend_data;
      end else begin
        mem_rvalid = 1'b0;
        mem_rdata = $urandom;
        if (pend_v) pend_cnt--;
      end
      mem_gnt = (int'($urandom_range(99)) < gnt_pct);
      ir = (int'($urandom_range(99)) < ir_pct);
      last_hs = mem_req && mem_gnt;
      if (last_hs) begin
        last_addr = mem_addr;
        hs_cnt++;
        hs_addr.push_back(mem_addr);
      end
      last_rv = mem_rvalid;
    end
  end

  // ---------------- reference model ----------------
  bit m_act = 0, m_disc = 0, m_infl = 0;
  logic [7:0] m_base = '0;
  int m_len = 0, m_gr = 0;
  logic [31:0] m_q [$];

  function automatic bit e_req();
    return m_act && (m_gr < m_len) && !m_infl
        && (m_q.size() < DEPTH);
  endfunction

  initial begin
    bit g, p, pend;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        m_act = 0; m_disc = 0; m_infl = 0;
        m_base = '0; m_len = 0; m_gr = 0;
        m_q.delete();
      end else begin
        g = e_req() && mem_gnt;
        p = (m_q.size() > 0) && ir;
        if (flush) begin
          pend = (m_infl && !mem_rvalid) || g;
          m_q.delete();
          m_act = 0;
          m_infl = pend;
          m_disc = pend;
        end else begin
          if (p) void'(m_q.pop_front());
          if (mem_rvalid && m_infl) begin
            if (m_disc) m_disc = 0;
            else m_q.push_back(mem_rdata);
            m_infl = 0;
          end
          if (g) begin
            m_infl = 1;
            m_gr++;
          end
          if (start && !m_act && !m_disc
              && prog_len != 0) begin
            m_act = 1;
            m_base = base_addr;
            m_len = int'(prog_len);
            m_gr = 0;
          end
          if (m_act && m_gr == m_len && !m_infl
              && m_q.size() == 0) m_act = 0;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    logic [31:0] h;
    bit ev;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        ev = (m_q.size() > 0);
        h = ev ? m_q[0] : 32'h0;
        chk("busy", 32'(busy), 32'(m_act || m_disc));
        chk("mem_req", 32'(mem_req), 32'(e_req()));
        if (e_req())
          chk("mem_addr", 32'(mem_addr),
              32'(8'(m_base + 8'(m_gr))));
        chk("iv", 32'(iv), 32'(ev));
        chk("op", 32'(op), 32'(h[31:30]));
        chk("mask", 32'(mask), 32'(h[29:26]));
        chk("dest", 32'(dest), 32'(h[25:23]));
        chk("src_a", 32'(src_a), 32'(h[22:20]));
        chk("src_b", 32'(src_b), 32'(h[19:17]));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(negedge clk); #2;
  endtask

  task automatic go(logic [7:0] b, logic [7:0] l);
    base_addr = b;
    prog_len = l;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic wait_idle(int maxc, string nm);
    int k = 0;
    while (busy && k < maxc) begin
      tick();
      k++;
    end
    chk({nm, " idle"}, 32'(busy), 0);
  endtask

  function automatic logic [7:0] ha(int k);
    if (k < hs_addr.size()) return hs_addr[k];
    return 8'hxx;
  endfunction

  initial begin
    int n, r, k;
    for (int i = 0; i < 256; i++) pmem[i] = $urandom;
    rst_n = 1'b0;
    repeat (3) tick();
    chk("rst busy", 32'(busy), 0);
    chk("rst req", 32'(mem_req), 0);
    chk("rst addr", 32'(mem_addr), 0);
    chk("rst iv", 32'(iv), 0);
    chk("rst fields",
        32'({op, mask, dest, src_a, src_b}), 0);
    rst_n = 1'b1;
    tick();

    // basic program, three words in order
    hs_addr.delete();
    go(8'h10, 8'd3);
    wait_idle(40, "t1");
    chk("t1 nreq", hs_addr.size(), 3);
    chk("t1 a0", 32'(ha(0)), 32'h10);
    chk("t1 a1", 32'(ha(1)), 32'h11);
    chk("t1 a2", 32'(ha(2)), 32'h12);

    // field decode of a known word
    pmem[8'h30] = 32'h7C14_0000;
    ir_pct = 0;
    go(8'h30, 8'd1);
    k = 0;
    while (!iv && k < 10) begin
      tick();
      k++;
    end
    chk("t2 iv", 32'(iv), 1);
    chk("t2 op", 32'(op), 1);
    chk("t2 mask", 32'(mask), 32'hF);
    chk("t2 dest", 32'(dest), 0);
    chk("t2 src_a", 32'(src_a), 1);
    chk("t2 src_b", 32'(src_b), 2);
    ir_pct = 100;
    wait_idle(20, "t2");

    // backpressure: FIFO fills, fetching stops at 4
    ir_pct = 0;
    hs_cnt = 0;
    go(8'h40, 8'd8);
    repeat (20) tick();
    chk("t3 fetched", hs_cnt, 4);
    chk("t3 req", 32'(mem_req), 0);
    chk("t3 iv", 32'(iv), 1);
    ir_pct = 100;
    wait_idle(80, "t3");
    chk("t3 total", hs_cnt, 8);

    // flush with a word in flight
    lat_min = 3; lat_max = 3;
    ir_pct = 0;
    hs_cnt = 0;
    go(8'h50, 8'd2);
    tick();
    do_flush();
    chk("t4 granted", hs_cnt, 1);
    chk("t4 busy disc", 32'(busy), 1);
    chk("t4 req off", 32'(mem_req), 0);
    go(8'h60, 8'd1);
    chk("t4 blocked req", 32'(mem_req), 0);
    chk("t4 blocked busy", 32'(busy), 1);
    chk("t4 iv", 32'(iv), 0);
    tick();
    chk("t4 released", 32'(busy), 0);
    chk("t4 iv drop", 32'(iv), 0);
    lat_min = 1; lat_max = 1;
    go(8'h60, 8'd1);
    chk("t4 restart busy", 32'(busy), 1);
    chk("t4 restart req", 32'(mem_req), 1);
    ir_pct = 100;
    wait_idle(20, "t4");

    // address wrap and zero-length start
    hs_addr.delete();
    go(8'hFE, 8'd4);
    wait_idle(40, "t5");
    chk("t5 nreq", hs_addr.size(), 4);
    chk("t5 a0", 32'(ha(0)), 32'hFE);
    chk("t5 a1", 32'(ha(1)), 32'hFF);
    chk("t5 a2", 32'(ha(2)), 32'h00);
    chk("t5 a3", 32'(ha(3)), 32'h01);
    go(8'h00, 8'd0);
    chk("t5 len0", 32'(busy), 0);
    chk("t5 len0 req", 32'(mem_req), 0);

    // async reset mid-program
    ir_pct = 0;
    go(8'h70, 8'd8);
    repeat (6) tick();
    chk("t6 pre iv", 32'(iv), 1);
    chk("t6 pre busy", 32'(busy), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("t6 iv", 32'(iv), 0);
    chk("t6 req", 32'(mem_req), 0);
    chk("t6 busy", 32'(busy), 0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    chk("t6 after", 32'(busy), 0);

    // randomized programs, flushes and stray starts
    for (int it = 0; it < 40; it++) begin
      gnt_pct = int'($urandom_range(100, 30));
      ir_pct = int'($urandom_range(100, 20));
      lat_min = 1;
      lat_max = int'($urandom_range(4, 1));
      go(8'($urandom), 8'($urandom_range(12, 0)));
      n = int'($urandom_range(50, 5));
      for (int c = 0; c < n; c++) begin
        r = int'($urandom_range(99));
        if (r < 3) do_flush();
        else if (r < 8)
          go(8'($urandom), 8'($urandom_range(6, 1)));
        else tick();
      end
      wait_idle(400, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
